// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding.
package pc_pkg;

    typedef logic [2:0] pc_sel_t;

    localparam pc_sel_t PC_SEL_HOLD   = 3'd0;
    localparam pc_sel_t PC_SEL_INC    = 3'd1;
    localparam pc_sel_t PC_SEL_LOAD   = 3'd2;
    localparam pc_sel_t PC_SEL_CALL   = 3'd3;
    localparam pc_sel_t PC_SEL_RET    = 3'd4;
    localparam pc_sel_t PC_SEL_RET_UF = 3'd5;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch-stage controller (master) and pc_unit (slave).
interface pc_unit_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic             ena;
    logic             load;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_out;
    logic [CW-1:0]    ras_count;
    logic             ras_uflow;
    logic             align_err;

    modport master (
        output ena, load, call, ret, target,
        input  pc_out, ras_count, ras_uflow, align_err
    );

    modport slave (
        input  ena, load, call, ret, target,
        output pc_out, ras_count, ras_uflow, align_err
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt_q;

    // wr_ptr points at the next free slot, so the top lives one below it
    assign top   = mem[wr_ptr - AW'(1)];
    assign count = cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (cnt_q != FULL) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (pop) begin
            wr_ptr <= wr_ptr - AW'(1);
            cnt_q  <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with call/return stack. Optional target alignment check
// enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0,
    parameter int unsigned       INC       = 4,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    pc_sel_t          sel;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] ras_top;
    logic [CW-1:0]    ras_cnt;
    logic             uflow_q;

    assign pc_inc = pc_q + WIDTH'(INC);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
    logic misaligned;
    logic align_q;

    assign misaligned = |(bus.target & ALIGN_MASK);
    assign tgt        = bus.target & ~ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            align_q <= 1'b0;
        end else begin
            align_q <= ((sel == PC_SEL_CALL) || (sel == PC_SEL_LOAD)) && misaligned;
        end
    end

    assign bus.align_err = align_q;
`else
    assign tgt           = bus.target;
    assign bus.align_err = 1'b0;
`endif

    // Priority call > load > ret > increment; the losers are simply dropped
    always_comb begin
        sel = PC_SEL_HOLD;
        if (bus.ena) begin
            if (bus.call) begin
                sel = PC_SEL_CALL;
            end else if (bus.load) begin
                sel = PC_SEL_LOAD;
            end else if (bus.ret) begin
                sel = (ras_cnt != '0) ? PC_SEL_RET : PC_SEL_RET_UF;
            end else begin
                sel = PC_SEL_INC;
            end
        end
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (sel == PC_SEL_CALL),
        .pop       (sel == PC_SEL_RET),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            uflow_q <= 1'b0;
        end else begin
            case (sel)
                PC_SEL_INC,
                PC_SEL_RET_UF: pc_q <= pc_inc;
                PC_SEL_LOAD,
                PC_SEL_CALL:   pc_q <= tgt;
                PC_SEL_RET:    pc_q <= ras_top;
                default:       pc_q <= pc_q;
            endcase
            if (sel == PC_SEL_RET_UF) begin
                uflow_q <= 1'b1;
            end
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.ras_count = ras_cnt;
    assign bus.ras_uflow = uflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed steps queue expected state, a monitor checks it.
module tb_pc_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pc_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

    pc_unit #(
        .WIDTH     (32),
        .RESET_VEC (32'h0),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] MIS_PC  = 32'h100;
    localparam logic [31:0] MIS_NXT = 32'h104;
    localparam bit          MIS_AL  = 1'b1;
`else
    localparam logic [31:0] MIS_PC  = 32'h103;
    localparam logic [31:0] MIS_NXT = 32'h107;
    localparam bit          MIS_AL  = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [31:0] pc;
        int          cnt;
        bit          uf;
        bit          al;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h (cycle %0d)", nm, fld, got, exp, cyc);
        end
    endtask

    // Monitor: after every edge, compare the outputs against all entries due by now
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk(e.name, "pc_out",    bus.pc_out,              e.pc);
                chk(e.name, "ras_count", 32'(bus.ras_count),      32'(e.cnt));
                chk(e.name, "ras_uflow", 32'(bus.ras_uflow),      32'(e.uf));
                chk(e.name, "align_err", 32'(bus.align_err),      32'(e.al));
            end
        end
    end

    task automatic st(input logic rs, input logic e, input logic l, input logic c, input logic r,
                      input logic [31:0] t, input logic [31:0] epc, input int ecnt,
                      input bit euf, input bit eal, input string nm);
        exp_t x;
        rst        = rs;
        bus.ena    = e;
        bus.load   = l;
        bus.call   = c;
        bus.ret    = r;
        bus.target = t;
        x.due  = cyc + 1;
        x.pc   = epc;
        x.cnt  = ecnt;
        x.uf   = euf;
        x.al   = eal;
        x.name = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        bus.ena = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.target = '0;

        // reset and plain increments
        st(1,0,0,0,0, 32'h0,   32'h0,   0,0,0, "rst0");
        st(1,0,0,0,0, 32'h0,   32'h0,   0,0,0, "rst1");
        st(0,1,0,0,0, 32'h0,   32'h4,   0,0,0, "inc1");
        st(0,1,0,0,0, 32'h0,   32'h8,   0,0,0, "inc2");
        st(0,1,0,0,0, 32'h0,   32'hC,   0,0,0, "inc3");
        st(0,1,0,0,0, 32'h0,   32'h10,  0,0,0, "inc4");
        // stall ignores load
        for (int i = 0; i < 3; i++) st(0,0,1,0,0, 32'h100, 32'h10, 0,0,0, "stall");
        st(0,1,1,0,0, 32'h100, 32'h100, 0,0,0, "load");
        // call / increment / return
        st(0,1,1,0,0, 32'h20,  32'h20,  0,0,0, "load20");
        st(0,1,0,1,0, 32'h400, 32'h400, 1,0,0, "call1");
        st(0,1,0,0,0, 32'h0,   32'h404, 1,0,0, "inc_in_callee");
        st(0,1,0,0,1, 32'h0,   32'h24,  0,0,0, "ret1");
        // five nested calls overflow the 4-deep stack
        st(0,1,1,0,0, 32'h0,   32'h0,   0,0,0, "load0");
        st(0,1,0,1,0, 32'h100, 32'h100, 1,0,0, "callA");
        st(0,1,0,1,0, 32'h200, 32'h200, 2,0,0, "callB");
        st(0,1,0,1,0, 32'h300, 32'h300, 3,0,0, "callC");
        st(0,1,0,1,0, 32'h400, 32'h400, 4,0,0, "callD");
        st(0,1,0,1,0, 32'h500, 32'h500, 4,0,0, "callE_full");
        st(0,1,0,0,1, 32'h0,   32'h404, 3,0,0, "retE");
        st(0,1,0,0,1, 32'h0,   32'h304, 2,0,0, "retD");
        st(0,1,0,0,1, 32'h0,   32'h204, 1,0,0, "retC");
        st(0,1,0,0,1, 32'h0,   32'h104, 0,0,0, "retB");
        st(0,1,0,0,1, 32'h0,   32'h108, 0,1,0, "ret_underflow");
        // wrap and priority
        st(0,1,1,0,0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0,1,0, "load_top");
        st(0,1,0,0,0, 32'h0,   32'h0,   0,1,0, "inc_wrap");
        st(0,1,1,1,1, 32'h600, 32'h600, 1,1,0, "call_wins");
        st(0,0,0,0,1, 32'h0,   32'h600, 1,1,0, "stall_ret");
        st(0,1,0,0,1, 32'h0,   32'h4,   0,1,0, "ret_after_wrap");
        st(0,1,0,1,0, 32'h700, 32'h700, 1,1,0, "call7");
        st(0,1,1,0,1, 32'h800, 32'h800, 1,1,0, "load_beats_ret");
        st(0,1,0,0,1, 32'h0,   32'h8,   0,1,0, "ret7");
        // misaligned target
        st(0,1,1,0,0, 32'h103, MIS_PC,  0,1,MIS_AL, "load_mis");
        st(0,1,0,0,0, 32'h0,   MIS_NXT, 0,1,0, "after_mis");
        // reset in the middle of a call chain
        st(0,1,1,0,0, 32'h0,   32'h0,   0,1,0, "load0b");
        st(0,1,0,1,0, 32'h10,  32'h10,  1,1,0, "callX");
        st(0,1,0,1,0, 32'h20,  32'h20,  2,1,0, "callY");
        st(0,1,0,1,0, 32'h30,  32'h30,  3,1,0, "callZ");
        st(1,1,0,1,0, 32'h40,  32'h0,   0,0,0, "rst_with_call");
        st(0,1,0,0,1, 32'h0,   32'h4,   0,1,0, "ret_after_rst");
        st(0,1,0,0,0, 32'h0,   32'h8,   0,1,0, "inc_end");

        bus.ena = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #5;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
